mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Parametrised sequential multiply/divide unit for the EX stage; owns HI/LO.
//  Generalises the fixed 32-bit MDU with WIDTH/latency parameters, accumulate ops
//  (MADD/MSUB), defined divide-by-zero results and a cancel input for exception flush.
//  The pipeline stalls any MD instruction in ID while (start | busy).
// PARAMETERS
//  WIDTH    32  operand width; hi/lo are WIDTH each, product is 2*WIDTH
//  MUL_LAT  5   busy cycles for MULT/MULTU/MADD*/MSUB* (>=1)
//  DIV_LAT  10  minimum busy cycles for DIV/DIVU; actual = max(DIV_LAT, WIDTH+1)
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-low reset
//  A       in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//  B       in   WIDTH  rt operand (divisor / multiplier)
//  MDU_OP  in   4      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD,8 MADDU,9 MSUB,10 MSUBU
//  start   in   1      one-cycle launch strobe, sampled with MDU_OP/A/B
//  cancel  in   1      abort in-flight op (exception/flush)
//  busy    out  1      operation in flight
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset==0, any time incl. mid-op): state IDLE, busy=0, hi=0, lo=0, counter=0.
//  States: IDLE, MUL, DIV, DIV_FIX.  IDLE accepts start; MUL/DIV/DIV_FIX ignore start.
//  Launch at edge k (start=1, busy=0, cancel=0): operands latched; busy=1 for cycles
//   k+1..k+N; hi/lo updated at edge k+N, busy=0 at the same edge; new hi/lo readable
//   from cycle k+N+1.  N = MUL_LAT (mult class) or max(DIV_LAT, WIDTH+1) (div class).
//  MTHI/MTLO: no busy; hi (resp. lo) <= A at edge k; other register unchanged.
//  MDU_OP=NONE or codes 11..15 with start: no effect, stay IDLE.
//  Multiply: product formed once from latched operands (signed for MULT/MADD/MSUB,
//   zero-extended for *U); held in a delay counter MUL_LAT cycles, then
//   MULT*: {hi,lo}<=P;  MADD*: {hi,lo}<={hi,lo}+P;  MSUB*: {hi,lo}<={hi,lo}-P,
//   all modulo 2^(2*WIDTH); accumulate uses the {hi,lo} value at completion edge.
//  Divide: restoring radix-2, one quotient bit per cycle on magnitudes (WIDTH cycles
//   in DIV), then DIV_FIX applies signs and pads to N.  lo=quotient (truncated toward
//   zero), hi=remainder (sign of dividend).
//  Divide boundaries: B==0 -> lo=all ones, hi=A (both DIV/DIVU), full latency still
//   taken.  DIV MIN_INT/-1 -> lo=MIN_INT, hi=0.
//  cancel: while busy, returns to IDLE next edge, busy=0, hi/lo unchanged.  cancel
//   with start in same cycle: start ignored (incl. MTHI/MTLO).  cancel in IDLE: no-op.
//  Completion edge with cancel=1: cancel wins, hi/lo unchanged.
// STRUCTURE
//  Shared header mdu_defs.vh: MDU_OP codes, state encodings, op-class helper macros
//   (is_mul, is_div, is_signed, is_acc); included by decode control and this block.
//  Sub-module mdu_div_core: WIDTH-parametrised restoring divider (load/step/done,
//   unsigned magnitudes in, quotient/remainder out); mdu_seq owns sign fix-up,
//   latency padding, div-by-zero and the HI/LO registers.
// TESTING (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
//  MULT A=20,B=30 start 1 cycle -> busy 5 cycles, then hi=0, lo=600; busy low.
//  MULT A=-3,B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU same -> hi=0x6, lo=0xFFFFFFEB.
//  DIV A=-7,B=2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=5,B=0 ->
//   lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  MTHI A=1, MTLO A=2, then MADD A=3,B=4 -> hi=1, lo=14; MSUBU A=1,B=15 -> hi=0, lo=0xFFFFFFFF.
//  DIV launched, cancel at busy cycle 10 -> busy=0 next cycle, hi/lo keep prior values;
//   start during busy ignored (result matches first op only).
//  reset pulled low mid-MULT -> busy=0, hi=lo=0 immediately; no completion afterwards.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states and
// op-class helpers used by decode control and the MDU itself.
package mdu_seq_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDivFix
  } mdu_state_e;

  function automatic logic is_mul(mdu_op_e op);
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_div(mdu_op_e op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic is_signed(mdu_op_e op);
    return op inside {OpMult, OpDiv, OpMadd, OpMsub};
  endfunction

  function automatic logic is_acc(mdu_op_e op);
    return op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_sub(mdu_op_e op);
    return op inside {OpMsub, OpMsubu};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: load, then one quotient bit per step.
// done_o rises once WIDTH steps have been taken since the last load.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign done_o      = (cnt_q == CntW'(WIDTH));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // quo_q doubles as the dividend shift register; quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      div_d = divisor_i;
      cnt_d = '0;
    end else if (step_i && !done_o) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit owning HI/LO: fixed-latency multiply/accumulate,
// restoring divide with sign fix-up and latency padding, and cancel for pipeline flush.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       MDU_OP,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DivN = (DIV_LAT > WIDTH + 1) ? DIV_LAT : WIDTH + 1;
  localparam int unsigned MaxN = (DivN > MUL_LAT) ? DivN : MUL_LAT;
  localparam int unsigned CntW = $clog2(MaxN + 1);
  localparam logic [CntW-1:0] MulCnt = CntW'(MUL_LAT);
  localparam logic [CntW-1:0] DivCnt = CntW'(DivN);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  mdu_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q;
  logic               acc_q, sub_q;
  logic [WIDTH-1:0]   a_q;
  logic               dz_q, negq_q, negr_q;

  mdu_op_e            op;
  logic               launch, sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, hilo, mul_res;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   quo, rem, div_hi, div_lo;
  logic               div_load, div_step, div_done;

  assign op     = mdu_op_e'(MDU_OP);
  assign launch = start & ~cancel & (state_q == StIdle);
  assign sgn    = is_signed(op);

  // Sign/zero extension to 2*WIDTH makes one unsigned multiplier serve both signednesses.
  assign ext_a = {{WIDTH{sgn & A[WIDTH-1]}}, A};
  assign ext_b = {{WIDTH{sgn & B[WIDTH-1]}}, B};
  assign prod  = ext_a * ext_b;
  assign mag_a = (sgn & A[WIDTH-1]) ? -A : A;
  assign mag_b = (sgn & B[WIDTH-1]) ? -B : B;

  assign hilo    = {hi_q, lo_q};
  assign mul_res = !acc_q ? prod_q : (sub_q ? hilo - prod_q : hilo + prod_q);

  assign div_hi = dz_q ? a_q : (negr_q ? -rem : rem);
  assign div_lo = dz_q ? '1  : (negq_q ? -quo : quo);

  assign div_load = launch & is_div(op);
  assign div_step = (state_q == StDiv);

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quotient_o (quo),
    .remainder_o(rem),
    .done_o     (div_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          if (is_mul(op)) begin
            state_d = StMul;
            cnt_d   = MulCnt;
          end else if (is_div(op)) begin
            state_d = StDiv;
            cnt_d   = DivCnt;
          end else if (op == OpMthi) begin
            hi_d = A;
          end else if (op == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StMul: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntOne) begin
          state_d      = StIdle;
          cnt_d        = '0;
          {hi_d, lo_d} = mul_res;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDiv, StDivFix: begin
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          hi_d    = div_hi;
          lo_d    = div_lo;
        end else begin
          cnt_d = cnt_q - CntOne;
          if (div_done) state_d = StDivFix;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand-derived context captured at launch, held for the whole operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      dz_q   <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (launch) begin
      prod_q <= prod;
      acc_q  <= is_acc(op);
      sub_q  <= is_sub(op);
      a_q    <= A;
      dz_q   <= (B == '0);
      negq_q <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
      negr_q <= sgn & A[WIDTH-1];
    end
  end

  assign busy = (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a vector table applied in order (HI/LO state carries over),
// then hand-written cancel, start-while-busy and mid-operation reset sequences.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  MDU_OP = '0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  mdu_seq #(
    .WIDTH  (32),
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDU_OP(MDU_OP),
    .start (start),
    .cancel(cancel),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Launch one op and count busy cycles; returns at #1 after the edge where busy drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    MDU_OP = op;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    MDU_OP = 4'd0;
    n      = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;

    vecs[0]  = '{4'd1,  32'd20,        32'd30,        32'h0,        32'd600,      5};
    vecs[1]  = '{4'd1,  32'hFFFFFFFD,  32'd7,         32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[2]  = '{4'd2,  32'hFFFFFFFD,  32'd7,         32'h6,        32'hFFFFFFEB, 5};
    vecs[3]  = '{4'd3,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4]  = '{4'd4,  32'd5,         32'd0,         32'd5,        32'hFFFFFFFF, 33};
    vecs[5]  = '{4'd3,  32'h80000000,  32'hFFFFFFFF,  32'h0,        32'h80000000, 33};
    vecs[6]  = '{4'd3,  32'd7,         32'hFFFFFFFE,  32'd1,        32'hFFFFFFFD, 33};
    vecs[7]  = '{4'd3,  32'hFFFFFFF8,  32'hFFFFFFFD,  32'hFFFFFFFE, 32'd2,        33};
    vecs[8]  = '{4'd3,  32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[9]  = '{4'd4,  32'hFFFFFFFF,  32'd16,        32'd15,       32'h0FFFFFFF, 33};
    vecs[10] = '{4'd0,  32'd7,         32'd7,         32'd15,       32'h0FFFFFFF, 0};
    vecs[11] = '{4'd11, 32'd7,         32'd7,         32'd15,       32'h0FFFFFFF, 0};
    vecs[12] = '{4'd5,  32'd1,         32'd9,         32'd1,        32'h0FFFFFFF, 0};
    vecs[13] = '{4'd6,  32'd2,         32'd9,         32'd1,        32'd2,        0};
    vecs[14] = '{4'd7,  32'd3,         32'd4,         32'd1,        32'd14,       5};
    vecs[15] = '{4'd10, 32'd1,         32'd15,        32'h0,        32'hFFFFFFFF, 5};
    vecs[16] = '{4'd9,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'h0,        32'hFFFFFFFE, 5};
    vecs[17] = '{4'd8,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'hFFFFFFFF, 5};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    // Cancel a divide at its 10th busy cycle; HI/LO must keep the MTHI/MTLO values.
    run_op(4'd5, 32'h0000AAAA, 32'd0, n);
    run_op(4'd6, 32'h00005555, 32'd0, n);
    MDU_OP = 4'd3;
    A      = 32'd100;
    B      = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("cancel_busy_before", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy_after", {31'b0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h0000AAAA);
    check("cancel_lo", lo, 32'h00005555);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_no_late_hi", hi, 32'h0000AAAA);
    check("cancel_no_late_lo", lo, 32'h00005555);

    // Start of MTHI while a MULT is busy must be ignored.
    MDU_OP = 4'd1;
    A      = 32'd6;
    B      = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    MDU_OP = 4'd5;
    A      = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start  = 1'b0;
    MDU_OP = 4'd0;
    n      = 1;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_start_cycles", 32'(n), 32'd5);
    check("busy_start_hi", hi, 32'd0);
    check("busy_start_lo", lo, 32'd42);

    // Cancel asserted on the completion edge wins.
    MDU_OP = 4'd1;
    A      = 32'd3;
    B      = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_last_busy", {31'b0, busy}, 32'd0);
    check("cancel_last_lo", lo, 32'd42);

    // Cancel together with start in IDLE: MTHI is dropped.
    MDU_OP = 4'd5;
    A      = 32'h00001234;
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    MDU_OP = 4'd0;
    check("cancel_start_busy", {31'b0, busy}, 32'd0);
    check("cancel_start_hi", hi, 32'd0);

    // Asynchronous reset in the middle of a MULT.
    MDU_OP = 4'd1;
    A      = 32'd2;
    B      = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midreset_after_busy", {31'b0, busy}, 32'd0);
    check("midreset_after_lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
